alu_div_seq: RTL

//  Iterative restoring divider/sequencer for the RV32M DIV/DIVU/REM/REMU ops the

---
 rtl/alu_div_seq_if.sv | 25 ++
 rtl/alu_div_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_div_seq_if.sv
// Handshake bundle between the EX pipeline (master) and the iterative divider (slave).
interface alu_div_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/alu_div_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// state | meaning
// IDLE  | ready for a new op
// CALC  | shifting/subtracting, XLEN iterations
// DONE  | result held until consumer takes it
module alu_div_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    alu_div_seq_if.slave  bus_if
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   div_q, div_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              rem_sel_q, rem_sel_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;

    logic              accept;
    logic              signed_op;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              div0, ovf;
    logic [XLEN:0]     rem_sh, diff;
    logic              ge;
    logic [XLEN-1:0]   rem_nx, quo_nx, q_fix, r_fix;

    assign accept    = bus_if.in_valid & bus_if.in_ready & ~bus_if.kill;
    assign signed_op = ~bus_if.op[0];
    assign a_neg     = signed_op & bus_if.a[XLEN-1];
    assign b_neg     = signed_op & bus_if.b[XLEN-1];
    assign a_abs     = a_neg ? -bus_if.a : bus_if.a;
    assign b_abs     = b_neg ? -bus_if.b : bus_if.b;
    assign div0      = (bus_if.b == '0);
    assign ovf       = signed_op & (bus_if.a == {1'b1, {(XLEN-1){1'b0}}}) & (bus_if.b == '1);

    // Borrow out of the XLEN+1-bit subtract decides the quotient bit.
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, div_q};
    assign ge     = ~diff[XLEN];
    assign rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx = {quo_q[XLEN-2:0], ge};
    assign q_fix  = neg_quo_q ? -quo_nx : quo_nx;
    assign r_fix  = neg_rem_q ? -rem_nx : rem_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus_if.kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = (div0 | ovf) ? S_DONE : S_CALC;
                S_CALC:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
                S_DONE:  if (bus_if.out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus_if.in_ready  = (state_q == S_IDLE) & ~rst;
        bus_if.busy      = (state_q != S_IDLE);
        bus_if.out_valid = (state_q == S_DONE);
        bus_if.result    = result_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        div_d     = div_q;
        result_d  = result_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (!bus_if.kill) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rem_sel_d = bus_if.op[1];
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        if (div0) begin
                            result_d = bus_if.op[1] ? bus_if.a : '1;
                        end else if (ovf) begin
                            result_d = bus_if.op[1] ? '0 : bus_if.a;
                        end else begin
                            rem_d = '0;
                            quo_d = a_abs;
                            div_d = b_abs;
                            cnt_d = CNT_W'(XLEN);
                        end
                    end
                end
                S_CALC: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) result_d = rem_sel_q ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            result_q  <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            result_q  <= result_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
endmodule
